spike_event_encoder: RTL and testbench

Reads the registered spike flags of one neuron layer after an update cycle and emits the index of every spiking neuron as an address event (AER), lowest index first, over a valid/ready handshake. It sits downstream of the neuron array and feeds the event router and synapse-weight fetch of the next layer. Event addresses are size_code bits wide.

---
 rtl/spike_event_encoder_pkg.sv | 14 +
 rtl/spike_event_encoder_lsb_prienc.sv | 23 ++
 rtl/spike_event_encoder.sv | 96 +++++++++
 tb/tb_spike_event_encoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spike_event_encoder_pkg.sv
// Shared definitions for the spike address-event encoder.
// Default layer width and the scan state encoding live here.
package spike_event_encoder_pkg;

    localparam int SIZE_CODE   = 5;
    localparam int NUM_NEURONS = 2 ** SIZE_CODE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/spike_event_encoder_lsb_prienc.sv
// Lowest-set-bit priority encoder.
// Reports the index of the lowest set bit and whether any bit is set.
module spike_lsb_prienc #(
    parameter int W = 5,
    parameter int N = 32
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        // Walk downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = i[W-1:0];
            end
        end
    end

endmodule

// File: rtl/spike_event_encoder.sv
// Snapshots a layer's spike flags and streams the indices of the
// spiking neurons as address events, lowest index first.
module spike_event_encoder
    import spike_event_encoder_pkg::*;
#(
    parameter int size_code   = SIZE_CODE,
    parameter int num_neurons = 2 ** size_code
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [num_neurons-1:0] spikes,
    output logic                   busy,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [size_code-1:0]   evt_addr,
    output logic                   done,
    output logic [size_code:0]     evt_count
);

    state_t                 r_state;
    logic [num_neurons-1:0] r_pending;
    logic                   r_busy;
    logic                   r_done;
    logic [size_code:0]     r_count;

    logic [size_code-1:0]   w_idx;
    logic                   w_any;
    logic                   w_accept;
    logic [num_neurons-1:0] w_rest;

    spike_lsb_prienc #(
        .W (size_code),
        .N (num_neurons)
    ) u_prienc (
        .i_vec (r_pending),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign evt_valid = (r_state == SCAN) && w_any;
    assign evt_addr  = evt_valid ? w_idx : '0;
    assign w_accept  = evt_valid && evt_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign evt_count = r_count;

    always_comb begin
        w_rest        = r_pending;
        w_rest[w_idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pending <= spikes;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_accept) begin
                        r_pending <= w_rest;
                        r_count   <= r_count + {{size_code{1'b0}}, 1'b1};
                        // Last event leaves directly so done follows it.
                        if (w_rest == '0) begin
                            r_done  <= 1'b1;
                            r_state <= FINISH;
                        end
                    end else if (!w_any) begin
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Randomised and directed bench for spike_event_encoder.
// A queue-based reference predicts every output on every cycle.
module tb_spike_event_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] spikes;
    logic        busy;
    logic        evt_valid;
    logic        evt_ready;
    logic [4:0]  evt_addr;
    logic        done;
    logic [5:0]  evt_count;

    int checks;
    int errors;
    bit chk_en;

    int m_q[$];
    bit m_scan;
    bit m_fin;
    int m_count;
    bit exp_v;

    int acc[$];
    int n_done;

    spike_event_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .spikes    (spikes),
        .busy      (busy),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_addr  (evt_addr),
        .done      (done),
        .evt_count (evt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    task automatic chk_list(input string name, input int exp[$]);
        checks++;
        if (acc != exp) begin
            errors++;
            $display("FAIL %s: got %p expected %p", name, acc, exp);
        end
    endtask

    // Reference: a snapshot is the ordered list of set bit indices;
    // each handshake pops the head; done follows the list emptying.
    always @(posedge clk) begin
        if (!reset) begin
            m_scan  = 1'b0;
            m_fin   = 1'b0;
            m_count = 0;
            m_q.delete();
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_scan) begin
            if (m_q.size() != 0 && evt_ready) begin
                void'(m_q.pop_front());
                m_count++;
                if (m_q.size() == 0) begin
                    m_scan = 1'b0;
                    m_fin  = 1'b1;
                end
            end else if (m_q.size() == 0) begin
                m_scan = 1'b0;
                m_fin  = 1'b1;
            end
        end else if (start) begin
            m_q.delete();
            for (int i = 0; i < 32; i++) begin
                if (spikes[i]) m_q.push_back(i);
            end
            m_count = 0;
            m_scan  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = m_scan && (m_q.size() != 0);
            chk("evt_valid", 32'(evt_valid), 32'(exp_v));
            chk("evt_addr", 32'(evt_addr), exp_v ? m_q[0] : 0);
            chk("busy", 32'(busy), 32'(m_scan || m_fin));
            chk("done", 32'(done), 32'(m_fin));
            chk("evt_count", 32'(evt_count), m_count);
            if (reset && evt_valid && evt_ready) acc.push_back(int'(evt_addr));
            if (done) n_done++;
        end
    end

    task automatic snap(input logic [31:0] sp, input int mode,
                        input logic [31:0] pat, input bit restart,
                        output int dc);
        int n0;
        dc = -1;
        acc.delete();
        n0 = n_done;
        @(posedge clk);
        #1;
        start  = 1'b1;
        spikes = sp;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            start  = (restart && k == 2);
            spikes = restart && k == 2 ? ~sp : $urandom;
            if (mode == 0) evt_ready = 1'b1;
            else if (mode == 1) evt_ready = (k <= 32) ? pat[k-1] : 1'b1;
            else evt_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) begin
                dc = k;
                break;
            end
        end
        if (dc < 0) begin
            errors++;
            $display("FAIL timeout waiting for done, spikes %h", sp);
        end
        @(negedge clk);
        chk("done_pulses", n_done - n0, 1);
    endtask

    int dc;
    int expl[$];
    logic [31:0] rsp;

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        n_done = 0;
        reset = 1'b0;
        start = 1'b1;
        spikes = 32'hFFFF_FFFF;
        evt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(evt_count), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        snap(32'h0000_0000, 0, 32'h0, 1'b0, dc);
        chk("empty_done_cycle", dc, 2);
        chk("empty_count", 32'(evt_count), 0);
        chk_list("empty_events", expl);

        snap(32'h8000_0011, 0, 32'h0, 1'b0, dc);
        chk("three_done_cycle", dc, 4);
        chk("three_count", 32'(evt_count), 3);
        expl = '{0, 4, 31};
        chk_list("three_events", expl);

        snap(32'h8000_0011, 1, 32'h0000_0034, 1'b0, dc);
        chk("stall_done_cycle", dc, 7);
        chk_list("stall_events", expl);

        snap(32'hFFFF_FFFF, 0, 32'h0, 1'b0, dc);
        chk("full_done_cycle", dc, 33);
        chk("full_count", 32'(evt_count), 32);
        expl.delete();
        for (int i = 0; i < 32; i++) expl.push_back(i);
        chk_list("full_events", expl);

        snap(32'h0000_0F00, 2, 32'h0, 1'b1, dc);
        expl = '{8, 9, 10, 11};
        chk_list("restart_ignored", expl);
        chk("restart_count", 32'(evt_count), 4);

        @(posedge clk);
        #1;
        start = 1'b1;
        spikes = 32'hFFFF_FFFF;
        evt_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(evt_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        begin
            int n0;
            n0 = n_done;
            repeat (5) @(negedge clk);
            chk("midrst_no_done", n_done - n0, 0);
        end

        for (int t = 0; t < 30; t++) begin
            rsp = $urandom;
            if (t % 3 == 1) rsp = rsp & $urandom & $urandom;
            if (t == 5) rsp = 32'h8000_0000;
            if (t == 6) rsp = 32'h0000_0001;
            snap(rsp, 2, 32'h0, t % 4 == 3, dc);
            expl.delete();
            for (int i = 0; i < 32; i++) if (rsp[i]) expl.push_back(i);
            chk_list("rand_events", expl);
            chk("rand_count", 32'(evt_count), expl.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
